// File: rtl/mem_arb_pkg.sv
// Types and constants shared by the memory port arbiter and its slot buffers.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT_RSP
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/riscv32_common.sv
// Shared request/response bundle types for the 32-bit memory interfaces.
package riscv32_common;

  typedef struct packed {
    logic        valid;
    logic        do_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req32;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } rsp32;

endpackage

// File: rtl/mem_arb_slot.sv
// One-entry holding buffer for a single requester. A pulse arriving at an
// empty slot is presented straight away so it can be granted without delay.
module mem_arb_slot
  import riscv32_common::*;
(
  input  logic clk,
  input  logic reset_n,
  input  req32 req_i,
  input  logic issue_i,
  output logic full_o,
  output req32 entry_o,
  output logic drop_o
);

  logic full_q, full_d;
  req32 entry_q, entry_d;
  logic capture;

  assign full_o  = full_q | req_i.valid;
  assign entry_o = full_q ? entry_q : req_i;
  assign drop_o  = req_i.valid & full_q & ~issue_i;

  // Store the pulse unless it is granted straight through from an empty slot.
  assign capture = req_i.valid & (full_q ? issue_i : ~issue_i);

  always_comb begin
    full_d  = capture | (full_q & ~issue_i);
    entry_d = capture ? req_i : entry_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between the icache and dcache requesters.
// Build option ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority with a starvation limit.
module mem_port_arbiter
  import riscv32_common::*;
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  req32       icache_req,
  output rsp32       icache_rsp,
  input  req32       dcache_req,
  output rsp32       dcache_rsp,
  output req32       mem_req,
  input  rsp32       mem_rsp,
  output logic       busy,
  output logic [1:0] overflow_err,
  output logic       timeout_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic      iFull, dFull, iDrop, dDrop;
  logic      issueI, issueD, grantValid;
  logic      rspMatch, timedOut;
  arb_port_e grantPort;
  req32      iEntry, dEntry, grantEntry;
  rsp32      rspOut;

  arb_state_t  state_q;
  arb_port_e   owner_q;
  logic [31:0] issuedAddr_q;
  logic [TW-1:0] timeoutCnt_q;
  req32        memReq_q;
  rsp32        iRsp_q, dRsp_q;
  logic [1:0]  overflow_q;
  logic        timeoutErr_q;

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_e lastGrant_q;
`else
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starveCnt_q;
`endif

  mem_arb_slot u_slot_i (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (icache_req),
    .issue_i (issueI),
    .full_o  (iFull),
    .entry_o (iEntry),
    .drop_o  (iDrop)
  );

  mem_arb_slot u_slot_d (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (dcache_req),
    .issue_i (issueD),
    .full_o  (dFull),
    .entry_o (dEntry),
    .drop_o  (dDrop)
  );

  always_comb begin
    grantValid = 1'b0;
    grantPort  = PORT_D;
    if (state_q == ARB_IDLE) begin
      if (iFull && dFull) begin
        grantValid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        grantPort = (lastGrant_q == PORT_I) ? PORT_D : PORT_I;
`else
        grantPort = (starveCnt_q == STARVE_MAX) ? PORT_I : PORT_D;
`endif
      end else if (iFull) begin
        grantValid = 1'b1;
        grantPort  = PORT_I;
      end else if (dFull) begin
        grantValid = 1'b1;
        grantPort  = PORT_D;
      end
    end
  end

  assign issueI     = grantValid && (grantPort == PORT_I);
  assign issueD     = grantValid && (grantPort == PORT_D);
  assign grantEntry = (grantPort == PORT_I) ? iEntry : dEntry;

  assign rspMatch = (state_q == ARB_WAIT_RSP) && mem_rsp.valid && (mem_rsp.addr == issuedAddr_q);
  assign timedOut = (state_q == ARB_WAIT_RSP) && !rspMatch && (timeoutCnt_q == TIMEOUT_LAST);

  // An aborted transaction still answers its owner, echoing the address with zero data.
  always_comb begin
    rspOut = '0;
    if (rspMatch) begin
      rspOut = mem_rsp;
    end else begin
      rspOut.addr = issuedAddr_q;
      rspOut.data = TIMEOUT_DATA;
    end
    rspOut.valid = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= PORT_I;
      issuedAddr_q <= '0;
      timeoutCnt_q <= '0;
      memReq_q     <= '0;
      iRsp_q       <= '0;
      dRsp_q       <= '0;
      overflow_q   <= '0;
      timeoutErr_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrant_q  <= PORT_I;
`else
      starveCnt_q  <= '0;
`endif
    end else begin
      memReq_q   <= '0;
      iRsp_q     <= '0;
      dRsp_q     <= '0;
      overflow_q <= overflow_q | {dDrop, iDrop};
      case (state_q)
        ARB_IDLE: begin
          if (grantValid) begin
            state_q        <= ARB_WAIT_RSP;
            memReq_q       <= grantEntry;
            memReq_q.valid <= 1'b1;
            owner_q        <= grantPort;
            issuedAddr_q   <= grantEntry.addr;
            timeoutCnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrant_q    <= grantPort;
`else
            if (grantPort == PORT_I) begin
              starveCnt_q <= '0;
            end else if (iFull && (starveCnt_q != STARVE_MAX)) begin
              starveCnt_q <= starveCnt_q + 1'b1;
            end
`endif
          end
        end
        ARB_WAIT_RSP: begin
          if (rspMatch || timedOut) begin
            state_q <= ARB_IDLE;
            if (owner_q == PORT_I) begin
              iRsp_q <= rspOut;
            end else begin
              dRsp_q <= rspOut;
            end
            if (timedOut) begin
              timeoutErr_q <= 1'b1;
            end
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_req      = memReq_q;
  assign icache_rsp   = iRsp_q;
  assign dcache_rsp   = dRsp_q;
  assign busy         = (state_q == ARB_WAIT_RSP);
  assign overflow_err = overflow_q;
  assign timeout_err  = timeoutErr_q;

endmodule
